// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a little-endian word count and words,
// writes them into CPU memory and releases the CPU from reset when done.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_DataAdr,
    output logic [31:0] Ext_WriteData,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [2:0] {S_HDR, S_CHK, S_DATA, S_WRITE, S_RUN, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] n_q, n_d;
    logic [31:0] k_q, k_d;
    logic [31:0] word_q, word_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_sh;
    logic        accept;

    assign in_ready     = (state_q == S_HDR) || (state_q == S_DATA);
    assign accept       = in_valid && in_ready;
    // Bytes arrive LSB first, so shift in from the top.
    assign word_sh      = {in_data, word_q[31:8]};
    assign Ext_MemWrite = (state_q == S_WRITE);
    assign Ext_DataAdr  = adr_q;
    assign Ext_WriteData = wdata_q;
    assign cpu_reset    = (state_q != S_RUN);
    assign done         = (state_q == S_RUN);
    assign err          = (state_q == S_ERR);
    assign busy         = (state_q == S_HDR) || (state_q == S_CHK) ||
                          (state_q == S_DATA) || (state_q == S_WRITE);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        n_d        = n_q;
        k_d        = k_q;
        word_d     = word_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_HDR: if (accept) begin
                word_d     = word_sh;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    n_d     = word_sh;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                k_d = '0;
                if (n_q == '0 || n_q > MAX_N) state_d = S_ERR;
                else                          state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                word_d     = word_sh;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    // Load the write port now so it is valid throughout WRITE.
                    adr_d   = BASE_ADDR + {k_q[29:0], 2'b00};
                    wdata_d = word_sh;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                k_d     = k_q + 32'd1;
                state_d = (k_q + 32'd1 < n_q) ? S_DATA : S_RUN;
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HDR;
            byte_cnt_q <= '0;
            n_q        <= '0;
            k_q        <= '0;
            word_q     <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            n_q        <= n_d;
            k_q        <= k_d;
            word_q     <= word_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; writes are checked against a scoreboard queue.
module tb_prog_loader;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, Ext_MemWrite, cpu_reset, busy, done, err;
    logic [31:0] Ext_DataAdr, Ext_WriteData;

    int total = 0;
    int bad   = 0;
    int nwr   = 0;
    logic [63:0] exp_q[$];

    prog_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .Ext_MemWrite(Ext_MemWrite), .Ext_DataAdr(Ext_DataAdr),
        .Ext_WriteData(Ext_WriteData), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (Ext_MemWrite === 1'b1) begin
            nwr++;
            if (exp_q.size() == 0) chk("extra_write", 32'd1, 32'd0);
            else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_adr", Ext_DataAdr, e[63:32]);
                chk("wr_dat", Ext_WriteData, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Call positioned at a negedge; returns at the negedge after acceptance.
    // While waiting for in_ready, junk is presented with in_valid=1.
    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < 50) begin
            in_valid = 1; in_data = 8'($urandom);
            @(negedge clk); t++;
        end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1; in_data = b;
        @(negedge clk);
        in_valid = 0; in_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8]);
            if (i < 3) idle(gap);
        end
    endtask

    task automatic send_data(input logic [31:0] adr, input logic [31:0] w, input int gap);
        exp_q.push_back({adr, w});
        send_word(w, gap);
        chk("wr_strobe_lat", {31'd0, Ext_MemWrite}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0;
        @(negedge clk);
        reset = 0;
        exp_q.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},  {31'd0, in_ready},     32'd1);
        chk({tag, "_busy"}, {31'd0, busy},         32'd1);
        chk({tag, "_cpur"}, {31'd0, cpu_reset},    32'd1);
        chk({tag, "_mw"},   {31'd0, Ext_MemWrite}, 32'd0);
        chk({tag, "_adr"},  Ext_DataAdr,           32'd0);
        chk({tag, "_wd"},   Ext_WriteData,         32'd0);
        chk({tag, "_done"}, {31'd0, done},         32'd0);
        chk({tag, "_err"},  {31'd0, err},          32'd0);
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_cpur"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_done"}, {31'd0, done},      32'd1);
        chk({tag, "_busy"}, {31'd0, busy},      32'd0);
        chk({tag, "_rdy"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_err"},  {31'd0, err},       32'd0);
    endtask

    task automatic bad_header(input logic [31:0] n, input string tag);
        int w0;
        do_reset();
        w0 = nwr;
        send_word(n, 0);
        chk({tag, "_chk_rdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_chk_err"}, {31'd0, err},      32'd0);
        @(negedge clk);
        chk({tag, "_err"},  {31'd0, err},       32'd1);
        chk({tag, "_cpur"}, {31'd0, cpu_reset}, 32'd1);
        chk({tag, "_rdy"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_busy"}, {31'd0, busy},      32'd0);
        in_valid = 1; in_data = 8'h55;
        idle(6);
        in_valid = 0;
        chk({tag, "_err_hold"}, {31'd0, err}, 32'd1);
        chk({tag, "_nowr"}, 32'(nwr - w0), 32'd0);
    endtask

    initial begin
        int w0;
        logic [31:0] d;
        @(negedge clk);
        do_reset();
        chk_reset_outs("rst");

        // Back-to-back stream
        send_word(32'd2, 0);
        send_data(32'h0, 32'h00500093, 0);
        chk("b2b_cpur_mid", {31'd0, cpu_reset}, 32'd1);
        send_data(32'h4, 32'hFFD00113, 0);
        @(negedge clk);
        chk_run("b2b");
        chk("b2b_adr_hold", Ext_DataAdr,   32'h4);
        chk("b2b_dat_hold", Ext_WriteData, 32'hFFD00113);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        idle(3);
        chk("run_hold", {31'd0, done}, 32'd1);

        // Reset from RUN restarts the load
        reset = 1;
        @(negedge clk);
        chk("run_rst_cpur", {31'd0, cpu_reset}, 32'd1);
        reset = 0;
        chk_reset_outs("rst2");

        // Same stream with 3 idle cycles between every byte
        w0 = nwr;
        send_word(32'd2, 3); idle(3);
        send_data(32'h0, 32'h00500093, 3); idle(3);
        send_data(32'h4, 32'hFFD00113, 3);
        @(negedge clk);
        chk_run("gap");
        idle(4);
        chk("gap_nwr", 32'(nwr - w0), 32'd2);
        chk("gap_sb_empty", 32'(exp_q.size()), 32'd0);

        bad_header(32'd0,  "n0");
        bad_header(32'd65, "n65");
        bad_header(32'h0100_0001, "nbig");

        // Maximum image
        do_reset();
        w0 = nwr;
        send_word(32'd64, 0);
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            send_data(32'(i * 4), d, (i % 5 == 0) ? 1 : 0);
        end
        chk("max_last_adr", Ext_DataAdr, 32'hFC);
        @(negedge clk);
        chk_run("max");
        chk("max_nwr", 32'(nwr - w0), 32'd64);

        // Reset mid-word must discard the partial bytes
        do_reset();
        send_word(32'd2, 0);
        send(8'hAA); send(8'hBB);
        do_reset();
        chk_reset_outs("rst3");
        w0 = nwr;
        send_word(32'd2, 0);
        send_data(32'h0, 32'h00500093, 0);
        send_data(32'h4, 32'hFFD00113, 0);
        @(negedge clk);
        chk_run("midrst");
        idle(3);
        chk("midrst_nwr", 32'(nwr - w0), 32'd2);
        chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0, as the byte address of the first loaded word.
REQ-002 The block SHALL have parameter MAX_WORDS, default 64, as the largest accepted word count.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  byte stream valid.
REQ-007 in_data  in  8  byte stream data.
REQ-008 in_ready  out  1  loader can accept a byte this cycle.
REQ-009 Ext_MemWrite  out  1  one-cycle write strobe to the CPU memory external port.
REQ-010 Ext_DataAdr  out  32  write byte address.
REQ-011 Ext_WriteData  out  32  write data word.
REQ-012 cpu_reset  out  1  reset to the CPU core; held high until the image is fully loaded.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  image loaded, CPU released.
REQ-015 err  out  1  bad header; CPU held in reset.

Function
REQ-016 A byte SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; a byte SHALL NOT be accepted in any other cycle.
REQ-017 Stream format SHALL be a 4-byte little-endian word count N, followed by N words, each 4 bytes little-endian (first byte = bits 7:0).
REQ-018 States SHALL be HDR, CHK, DATA, WRITE, RUN, ERR.
REQ-019 HDR: in_ready=1 and busy=1; after the 4th header byte is accepted, the next state SHALL be CHK.
REQ-020 CHK (one cycle, in_ready=0): if N==0 or N>MAX_WORDS the next state SHALL be ERR, otherwise DATA with word index k=0.
REQ-021 DATA: in_ready=1; after the 4th byte of a word is accepted, the next state SHALL be WRITE.
REQ-022 WRITE (exactly one cycle, in_ready=0): Ext_MemWrite=1, Ext_DataAdr=BASE_ADDR+4*k, Ext_WriteData=assembled word; k SHALL then increment.
REQ-023 After WRITE the next state SHALL be DATA if k+1<N, otherwise RUN.
REQ-024 RUN: cpu_reset=0, done=1, busy=0, in_ready=0; the block SHALL remain in RUN until reset.
REQ-025 ERR: err=1, cpu_reset=1, busy=0, in_ready=0; the block SHALL remain in ERR until reset.
REQ-026 Ext_MemWrite SHALL be 0 in every state except WRITE; Ext_DataAdr and Ext_WriteData SHALL hold their last values outside WRITE.
REQ-027 Address arithmetic SHALL be 32-bit modulo 2^32; the N comparison SHALL use the full 32-bit header value.
REQ-028 Latency: the write strobe SHALL occur on the cycle immediately after acceptance of a word's 4th byte; cpu_reset SHALL fall on the cycle immediately after the final WRITE.
REQ-029 Idle cycles (in_valid=0) anywhere in the stream SHALL only stall the loader, with no effect on content or ordering.
REQ-030 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-031 While reset=1 at a rising edge, the state SHALL become HDR, with byte counter=0, k=0 and N=0.
REQ-032 Outputs after reset SHALL be: in_ready=1, busy=1, cpu_reset=1, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, done=0, err=0.
REQ-033 Reset asserted mid-header or mid-word SHALL discard all partial bytes; no write SHALL be issued for the discarded word.
REQ-034 Reset asserted in RUN SHALL reassert cpu_reset on the next edge and restart the load.

Verification
REQ-035 Reset for 1 cycle -> all outputs match REQ-032; in_ready=1.
REQ-036 Back-to-back bytes 02 00 00 00, 93 00 50 00, 13 01 D0 FF -> Ext_MemWrite pulses with (0x0, 0x00500093) and then (0x4, 0xFFD00113); cpu_reset=0 and done=1 on the cycle after the second pulse.
REQ-037 Same stream as REQ-036 with in_valid dropped for 3 cycles between each byte -> identical writes in the same order; no extra Ext_MemWrite pulses.
REQ-038 Header 00 00 00 00 -> err=1 two cycles after the 4th byte, cpu_reset stays 1, in_ready=0, no writes issued.
REQ-039 Header 41 00 00 00 (N=65 with MAX_WORDS=64) -> err=1 and no writes; header 40 00 00 00 followed by 64 words -> last write at address 0xFC, then done=1.
REQ-040 Reset after 2 data bytes of word 0, then the full stream of REQ-036 -> writes only as in REQ-036; the first word is not corrupted by the pre-reset bytes.
